txc_pes_rx: RTL and testbench

TXC_PES_RX -- requirements
Module: txc_pes_rx

---
 rtl/txc_pes_rx.sv | 127 ++++++++++++
 tb/tb_txc_pes_rx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txc_pes_rx.sv
// PES-to-TXC descriptor receive FIFO with credit return and flush.
// Optional TXC_PES_RX_STATS_EN adds the stat_desc_cnt accepted-push counter.
module txc_pes_rx #(
  parameter int DEPTH  = 8,
  parameter int PORT_W = 4,
  parameter int LEN_W  = 14,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1,
  localparam int DW    = PORT_W + 3 + LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pes_vld,
  input  logic [PORT_W-1:0] pes_port,
  input  logic [2:0]        pes_tc,
  input  logic [LEN_W-1:0]  pes_len,
  output logic              txc_vld,
  input  logic              txc_rdy,
  output logic [PORT_W-1:0] txc_port,
  output logic [2:0]        txc_tc,
  output logic [LEN_W-1:0]  txc_len,
  output logic [1:0]        crd_ret,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              err_ovf,
  output logic [CW-1:0]     fifo_cnt
`ifdef TXC_PES_RX_STATS_EN
  ,
  output logic [31:0]       stat_desc_cnt
`endif
);

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_crd;
  logic            r_done;
  logic            r_ovf;

  logic            w_run;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_disc;
  logic [1:0]      w_crd;

  assign w_run   = (r_state == S_RUN);
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign txc_vld = w_run && !w_empty;

  // In FLUSH the head drains unconditionally, one entry per cycle.
  assign w_pop  = w_run ? (txc_vld && txc_rdy) : !w_empty;
  assign w_push = w_run && pes_vld && (!w_full || w_pop);
  assign w_drop = w_run && pes_vld && w_full && !w_pop;
  assign w_disc = !w_run && pes_vld;
  assign w_crd  = {1'b0, w_pop} + {1'b0, w_disc};

  assign {txc_port, txc_tc, txc_len} = r_mem[r_rd];

  assign crd_ret    = r_crd;
  assign flush_done = r_done;
  assign err_ovf    = r_ovf;
  assign fifo_cnt   = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {pes_port, pes_tc, pes_len};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_crd <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_crd <= w_crd;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (flush_req) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_empty) begin
            r_state <= S_RUN;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef TXC_PES_RX_STATS_EN
  logic [31:0] r_stat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_stat <= '0;
    else if (w_push) r_stat <= r_stat + 32'd1;
  end

  assign stat_desc_cnt = r_stat;
`endif

endmodule

// File: tb/tb_txc_pes_rx.sv
// Directed self-checking bench for txc_pes_rx.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_txc_pes_rx;

  localparam int PORT_W = 4;
  localparam int LEN_W  = 14;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pes_vld;
  logic [PORT_W-1:0] pes_port;
  logic [2:0]        pes_tc;
  logic [LEN_W-1:0]  pes_len;
  logic              txc_vld;
  logic              txc_rdy;
  logic [PORT_W-1:0] txc_port;
  logic [2:0]        txc_tc;
  logic [LEN_W-1:0]  txc_len;
  logic [1:0]        crd_ret;
  logic              flush_req;
  logic              flush_done;
  logic              err_ovf;
  logic [CW-1:0]     fifo_cnt;
`ifdef TXC_PES_RX_STATS_EN
  logic [31:0]       stat_desc_cnt;
`endif

  int total = 0;
  int bad   = 0;

  txc_pes_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pes_vld    (pes_vld),
    .pes_port   (pes_port),
    .pes_tc     (pes_tc),
    .pes_len    (pes_len),
    .txc_vld    (txc_vld),
    .txc_rdy    (txc_rdy),
    .txc_port   (txc_port),
    .txc_tc     (txc_tc),
    .txc_len    (txc_len),
    .crd_ret    (crd_ret),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .err_ovf    (err_ovf),
    .fifo_cnt   (fifo_cnt)
`ifdef TXC_PES_RX_STATS_EN
    ,
    .stat_desc_cnt (stat_desc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int port, input logic rdy);
    pes_vld  = v;
    pes_port = PORT_W'(port);
    pes_tc   = 3'(port);
    pes_len  = LEN_W'(port * 10);
    txc_rdy  = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 0, 1'b0);
    flush_req = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush_req = 1'b0;
    drive(1'b0, 0, 1'b0);
    #3;
    total++;
    if (fifo_cnt !== 4'd0 || txc_vld !== 1'b0 || crd_ret !== 2'd0 ||
        flush_done !== 1'b0 || err_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset: cnt=%0d vld=%b crd=%0d done=%b ovf=%b want 0",
               fifo_cnt, txc_vld, crd_ret, flush_done, err_ovf);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [1:0] exp_crd [4];
    exp_crd = '{2'd0, 2'd1, 2'd1, 2'd1};
    for (int i = 1; i <= 4; i++) begin
      drive(i <= 3, i, 1'b1);
      tick();
      total++;
      if (crd_ret !== exp_crd[i-1]) begin
        bad++;
        $display("FAIL basic_crd[%0d]: got %0d want %0d", i, crd_ret, exp_crd[i-1]);
      end
      if (i <= 3) begin
        total++;
        if (txc_vld !== 1'b1 || txc_port !== PORT_W'(i) || txc_len !== LEN_W'(i*10)) begin
          bad++;
          $display("FAIL basic_head[%0d]: vld=%b port=%0d len=%0d want 1 %0d %0d",
                   i, txc_vld, txc_port, txc_len, i, i*10);
        end
      end
    end
    total++;
    if (txc_vld !== 1'b0 || fifo_cnt !== 4'd0) begin
      bad++;
      $display("FAIL basic_empty: vld=%b cnt=%0d want 0 0", txc_vld, fifo_cnt);
    end
    drive(1'b0, 0, 1'b0);
    tick();
    total++;
    if (crd_ret !== 2'd0) begin
      bad++;
      $display("FAIL basic_crd_idle: got %0d want 0", crd_ret);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
      total++;
      if (crd_ret !== 2'd0 || err_ovf !== (i == 9)) begin
        bad++;
        $display("FAIL ovf_push[%0d]: crd=%0d ovf=%b want 0 %b", i, crd_ret, err_ovf, i == 9);
      end
    end
    total++;
    if (fifo_cnt !== 4'd8 || txc_port !== 4'd1 || txc_tc !== 3'd1) begin
      bad++;
      $display("FAIL ovf_full: cnt=%0d port=%0d tc=%0d want 8 1 1", fifo_cnt, txc_port, txc_tc);
    end
    drive(1'b0, 0, 1'b0);
    tick();
    tick();
    total++;
    if (err_ovf !== 1'b1 || fifo_cnt !== 4'd8) begin
      bad++;
      $display("FAIL ovf_sticky: ovf=%b cnt=%0d want 1 8", err_ovf, fifo_cnt);
    end
  endtask

  task automatic test_full_pushpop();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
    end
    drive(1'b1, 10, 1'b1);
    tick();
    total++;
    if (fifo_cnt !== 4'd8 || err_ovf !== 1'b0 || crd_ret !== 2'd1 || txc_port !== 4'd2) begin
      bad++;
      $display("FAIL full_pushpop: cnt=%0d ovf=%b crd=%0d port=%0d want 8 0 1 2",
               fifo_cnt, err_ovf, crd_ret, txc_port);
    end
    drive(1'b0, 0, 1'b0);
  endtask

  task automatic test_flush();
    int sum;
    bit seen;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
    end
    drive(1'b0, 0, 1'b0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    total++;
    if (txc_vld !== 1'b0 || fifo_cnt !== 4'd5 || crd_ret !== 2'd0) begin
      bad++;
      $display("FAIL flush_enter: vld=%b cnt=%0d crd=%0d want 0 5 0", txc_vld, fifo_cnt, crd_ret);
    end
    drive(1'b1, 12, 1'b1);
    tick();
    drive(1'b0, 0, 1'b1);
    total++;
    if (crd_ret !== 2'd2 || fifo_cnt !== 4'd4) begin
      bad++;
      $display("FAIL flush_first: crd=%0d cnt=%0d want 2 4", crd_ret, fifo_cnt);
    end
    sum  = int'(crd_ret);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      sum += int'(crd_ret);
      if (flush_done === 1'b1) seen = 1'b1;
      total++;
      if (txc_vld !== 1'b0) begin
        bad++;
        $display("FAIL flush_vld[%0d]: got %b want 0", c, txc_vld);
      end
    end
    total++;
    if (!seen || sum != 6 || fifo_cnt !== 4'd0) begin
      bad++;
      $display("FAIL flush_done: seen=%b credits=%0d cnt=%0d want 1 6 0", seen, sum, fifo_cnt);
    end
    tick();
    total++;
    if (flush_done !== 1'b0) begin
      bad++;
      $display("FAIL flush_pulse: got %b want 0", flush_done);
    end
    drive(1'b1, 9, 1'b0);
    tick();
    drive(1'b0, 0, 1'b0);
    total++;
    if (txc_vld !== 1'b1 || txc_port !== 4'd9) begin
      bad++;
      $display("FAIL flush_run: vld=%b port=%0d want 1 9", txc_vld, txc_port);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
    end
    drive(1'b1, 5, 1'b1);
    tick();
    drive(1'b0, 0, 1'b0);
    total++;
    if (fifo_cnt !== 4'd4 || crd_ret !== 2'd1) begin
      bad++;
      $display("FAIL mid_pre: cnt=%0d crd=%0d want 4 1", fifo_cnt, crd_ret);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (fifo_cnt !== 4'd0 || txc_vld !== 1'b0 || crd_ret !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset: cnt=%0d vld=%b crd=%0d want 0 0 0", fifo_cnt, txc_vld, crd_ret);
    end
    tick();
    rst_n = 1'b1;
    drive(1'b1, 7, 1'b0);
    total++;
    if (txc_vld !== 1'b0) begin
      bad++;
      $display("FAIL mid_bypass: vld=%b want 0", txc_vld);
    end
    tick();
    drive(1'b0, 0, 1'b0);
    total++;
    if (txc_vld !== 1'b1 || txc_port !== 4'd7 || fifo_cnt !== 4'd1) begin
      bad++;
      $display("FAIL mid_push: vld=%b port=%0d cnt=%0d want 1 7 1", txc_vld, txc_port, fifo_cnt);
    end
  endtask

`ifdef TXC_PES_RX_STATS_EN
  task automatic test_stats();
    do_reset();
    force dut.r_stat = 32'hFFFF_FFFF;
    #1;
    release dut.r_stat;
    for (int i = 1; i <= 2; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
    end
    total++;
    if (stat_desc_cnt !== 32'h0000_0001) begin
      bad++;
      $display("FAIL stats_wrap: got %h want 00000001", stat_desc_cnt);
    end
    for (int i = 3; i <= 9; i++) begin
      drive(1'b1, i, 1'b0);
      tick();
    end
    drive(1'b0, 0, 1'b0);
    total++;
    if (stat_desc_cnt !== 32'h0000_0007) begin
      bad++;
      $display("FAIL stats_drop: got %h want 00000007", stat_desc_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_flush();
    test_reset_mid();
`ifdef TXC_PES_RX_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
